conv_seq_ctrl: RTL and testbench

CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

---
 rtl/conv_seq_ctrl_if.sv | 26 ++
 rtl/conv_seq_ctrl.sv | 170 +++++++++++++++++
 tb/tb_conv_seq_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_seq_ctrl_if.sv
// rtl/conv_seq_ctrl_if.sv - column-read and result handshake bundle for the conv sequencer
interface conv_seq_ctrl_if #(
    parameter int RW = 4,
    parameter int CW = 4
);
    logic          col_rd_req;
    logic [RW-1:0] col_rd_row;
    logic [CW-1:0] col_rd_col;
    logic          col_rd_valid;
    logic          res_valid;
    logic          res_ready;
    logic [RW-1:0] res_row;
    logic [CW-1:0] res_col;

    modport master (
        output col_rd_req, col_rd_row, col_rd_col,
        output res_valid, res_row, res_col,
        input  col_rd_valid, res_ready
    );

    modport slave (
        input  col_rd_req, col_rd_row, col_rd_col,
        input  res_valid, res_row, res_col,
        output col_rd_valid, res_ready
    );
endinterface

// File: rtl/conv_seq_ctrl.sv
// rtl/conv_seq_ctrl.sv - sliding-window convolution sequencer: column fetch, PE strobes, result handshake
module conv_seq_ctrl #(
    parameter int K_H  = 3,
    parameter int K_W  = 3,
    parameter int IN_H = 16,
    parameter int IN_W = 15
) (
    input  logic                  clk,
    input  logic                  rst_ni,
    input  logic                  start,
    input  logic                  abort,
    conv_seq_ctrl_if.master       bus,
    output logic                  img_load_en,
    output logic                  pe_clear,
    output logic                  pe_trigger,
    output logic                  minus_phase,
    output logic                  w_shift,
    output logic                  busy,
    output logic                  done
);
    localparam int OUT_H = IN_H - K_H + 1;
    localparam int OUT_W = IN_W - K_W + 1;
    localparam int RW    = $clog2(IN_H);
    localparam int CW    = $clog2(IN_W);
    localparam int NW    = $clog2(K_W + 1);

    localparam logic [RW-1:0] LAST_ROW = RW'(OUT_H - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(OUT_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FILL,
        S_CAL,
        S_MINUS,
        S_EMIT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] orow_q, orow_d;
    logic [CW-1:0] ocol_q, ocol_d;
    logic [NW-1:0] need_q, need_d;
    logic [NW-1:0] fetched_q, fetched_d;

    logic          fill_req;
    logic          fill_load;
    logic [CW-1:0] fill_col;

    // A full refill fetches columns ocol..ocol+K_W-1; a slide fetches only the new rightmost column.
    assign fill_col  = ocol_q + CW'(K_W) - CW'(need_q) + CW'(fetched_q);
    assign fill_req  = (state_q == S_FILL) && (fetched_q < need_q);
    assign fill_load = fill_req && bus.col_rd_valid;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            orow_q    <= '0;
            ocol_q    <= '0;
            need_q    <= '0;
            fetched_q <= '0;
        end else begin
            state_q   <= state_d;
            orow_q    <= orow_d;
            ocol_q    <= ocol_d;
            need_q    <= need_d;
            fetched_q <= fetched_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        orow_d         = orow_q;
        ocol_d         = ocol_q;
        need_d         = need_q;
        fetched_d      = fetched_q;
        bus.col_rd_req = 1'b0;
        bus.col_rd_row = '0;
        bus.col_rd_col = '0;
        bus.res_valid  = 1'b0;
        bus.res_row    = '0;
        bus.res_col    = '0;
        img_load_en    = 1'b0;
        pe_clear       = 1'b0;
        pe_trigger     = 1'b0;
        minus_phase    = 1'b0;
        w_shift        = 1'b0;
        done           = 1'b0;
        busy           = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_CLR;
                    orow_d    = '0;
                    ocol_d    = '0;
                    need_d    = NW'(K_W);
                    fetched_d = '0;
                end
            end
            S_CLR: begin
                pe_clear = 1'b1;
                state_d  = S_FILL;
            end
            S_FILL: begin
                bus.col_rd_req = fill_req;
                bus.col_rd_row = orow_q;
                bus.col_rd_col = fill_col;
                img_load_en    = fill_load;
                if (fill_load) begin
                    if (fetched_q + NW'(1) == need_q) begin
                        state_d   = S_CAL;
                        fetched_d = '0;
                    end else begin
                        fetched_d = fetched_q + NW'(1);
                    end
                end
            end
            S_CAL: begin
                pe_trigger = 1'b1;
                state_d    = S_MINUS;
            end
            S_MINUS: begin
                pe_trigger  = 1'b1;
                minus_phase = 1'b1;
                w_shift     = 1'b1;
                state_d     = S_EMIT;
            end
            S_EMIT: begin
                bus.res_valid = 1'b1;
                bus.res_row   = orow_q;
                bus.res_col   = ocol_q;
                if (bus.res_ready) begin
                    if (ocol_q != LAST_COL) begin
                        ocol_d  = ocol_q + CW'(1);
                        need_d  = NW'(1);
                        state_d = S_CLR;
                    end else if (orow_q != LAST_ROW) begin
                        ocol_d  = '0;
                        orow_d  = orow_q + RW'(1);
                        need_d  = NW'(K_W);
                        state_d = S_CLR;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_d   = S_IDLE;
                orow_d    = '0;
                ocol_d    = '0;
                need_d    = '0;
                fetched_d = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over every other transition, including a coincident start or handshake.
        if (abort) begin
            state_d   = S_IDLE;
            orow_d    = '0;
            ocol_d    = '0;
            need_d    = '0;
            fetched_d = '0;
        end
    end
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb/tb_conv_seq_ctrl.sv - self-checking bench for conv_seq_ctrl with a window-order reference model
module tb_conv_seq_ctrl;
    localparam int KW = 3;
    localparam int OH = 14;
    localparam int OW = 13;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic img_load_en, pe_clear, pe_trigger, minus_phase, w_shift, busy, done;

    conv_seq_ctrl_if #(.RW(4), .CW(4)) bus();

    conv_seq_ctrl dut (
        .clk         (clk),
        .rst_ni      (rst_ni),
        .start       (start),
        .abort       (abort),
        .bus         (bus),
        .img_load_en (img_load_en),
        .pe_clear    (pe_clear),
        .pe_trigger  (pe_trigger),
        .minus_phase (minus_phase),
        .w_shift     (w_shift),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int r;
        int c;
    } pos_t;

    typedef struct {
        int vprob;
        int rprob;
        int exp_res;
        int exp_loads;
        int exp_trig;
        int exp_done;
    } vec_t;

    pos_t exp_rd[$];
    pos_t exp_res[$];
    vec_t tbl[4];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int loads, cals, minuses, results, dones, clr_cyc;
    int vprob, rprob;
    int stall_row, stall_col;
    bit rnd = 1'b0;
    bit zw = 1'b0;
    bit stall_pend = 1'b0;
    bit prev_rv = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int outs_word();
        logic [24:0] w;
        w = {bus.col_rd_req, bus.col_rd_row, bus.col_rd_col, img_load_en, pe_clear,
             pe_trigger, minus_phase, w_shift, bus.res_valid, bus.res_row, bus.res_col,
             busy, done};
        return int'(w);
    endfunction

    // Reference order: row-major windows; column 0 of each row loads KW columns, later ones slide by one.
    function automatic void build_expect();
        exp_rd.delete();
        exp_res.delete();
        for (int r = 0; r < OH; r++) begin
            for (int c = 0; c < OW; c++) begin
                exp_res.push_back('{r, c});
                if (c == 0) begin
                    for (int k = 0; k < KW; k++) exp_rd.push_back('{r, k});
                end else begin
                    exp_rd.push_back('{r, c + KW - 1});
                end
            end
        end
    endfunction

    task automatic clear_counts();
        loads = 0; cals = 0; minuses = 0; results = 0; dones = 0; clr_cyc = 0;
        stall_pend = 1'b0;
    endtask

    task automatic monitor();
        pos_t e;
        cyc++;
        if (stall_pend)
            check("rd_hold", int'({bus.col_rd_req, bus.col_rd_row, bus.col_rd_col}),
                  int'({1'b1, 4'(stall_row), 4'(stall_col)}));
        stall_pend = bus.col_rd_req && !bus.col_rd_valid;
        stall_row  = int'(bus.col_rd_row);
        stall_col  = int'(bus.col_rd_col);
        if (img_load_en) begin
            loads++;
            if (exp_rd.size() == 0) check("rd_extra", 1, 0);
            else begin
                e = exp_rd.pop_front();
                check("rd_addr", int'(bus.col_rd_row) * 100 + int'(bus.col_rd_col), e.r * 100 + e.c);
            end
        end
        if (pe_clear) clr_cyc = cyc;
        if (pe_trigger) begin
            if (minus_phase) begin
                minuses++;
                check("minus_wshift", int'(w_shift), 1);
            end else cals++;
        end
        if (zw && bus.res_valid && !prev_rv)
            check("win_latency", cyc - clr_cyc, (int'(bus.res_col) == 0 ? KW : 1) + 3);
        if (bus.res_valid && bus.res_ready) begin
            results++;
            if (exp_res.size() == 0) check("res_extra", 1, 0);
            else begin
                e = exp_res.pop_front();
                check("res_pos", int'(bus.res_row) * 100 + int'(bus.res_col), e.r * 100 + e.c);
            end
        end
        if (done) dones++;
        if (!busy)
            check("idle_quiet", int'({pe_trigger, pe_clear, img_load_en, w_shift, done}), 0);
        prev_rv = bus.res_valid;
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #2;
        if (rnd) begin
            bus.col_rd_valid = ($urandom_range(99) < vprob);
            bus.res_ready    = ($urandom_range(99) < rprob);
            start = done ? 1'b1 : (busy && $urandom_range(9) == 0);
        end
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int n;
        d0 = dones;
        n = 0;
        while (dones == d0 && n < budget) begin
            step();
            n++;
        end
        check("sweep_timeout", int'(dones > d0), 1);
    endtask

    task automatic final_counts(input vec_t v);
        check("busy_after_done", int'(busy), 0);
        check("res_count", results, v.exp_res);
        check("load_count", loads, v.exp_loads);
        check("cal_count", cals, v.exp_trig);
        check("minus_count", minuses, v.exp_trig);
        check("done_count", dones, v.exp_done);
        check("res_left", exp_res.size(), 0);
        check("rd_left", exp_rd.size(), 0);
    endtask

    task automatic run_sweep(input vec_t v);
        build_expect();
        clear_counts();
        vprob = v.vprob;
        rprob = v.rprob;
        zw = (v.vprob == 100) && (v.rprob == 100);
        bus.col_rd_valid = 1'b1;
        bus.res_ready = 1'b1;
        start = 1'b1;
        rnd = 1'b1;
        wait_done(20000);
        rnd = 1'b0;
        zw = 1'b0;
        start = 1'b0;
        final_counts(v);
    endtask

    initial begin
        bit bp_done;
        bit st_done;
        bit hit;
        int n;

        tbl[0] = '{100, 100, OH * OW, OH * (KW + OW - 1), OH * OW, 1};
        tbl[1] = '{60, 100, OH * OW, OH * (KW + OW - 1), OH * OW, 1};
        tbl[2] = '{100, 55, OH * OW, OH * (KW + OW - 1), OH * OW, 1};
        tbl[3] = '{45, 50, OH * OW, OH * (KW + OW - 1), OH * OW, 1};

        bus.col_rd_valid = 1'b0;
        bus.res_ready = 1'b0;
        clear_counts();
        repeat (3) @(posedge clk);
        #2;
        check("reset_outs", outs_word(), 0);
        rst_ni = 1'b1;
        bus.col_rd_valid = 1'b1;
        bus.res_ready = 1'b1;
        repeat (3) step();
        check("idle_no_start", outs_word(), 0);

        for (int i = 0; i < 4; i++) run_sweep(tbl[i]);

        // Backpressure at (0,5) and a read stall during the row-1 refill, in one sweep.
        build_expect();
        clear_counts();
        bp_done = 1'b0;
        st_done = 1'b0;
        bus.col_rd_valid = 1'b1;
        bus.res_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (dones == 0 && n < 5000) begin
            if (!bp_done && bus.res_valid && int'(bus.res_row) == 0 && int'(bus.res_col) == 5) begin
                bp_done = 1'b1;
                bus.res_ready = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    step();
                    check("bp_hold", int'({bus.res_valid, bus.res_row, bus.res_col}), int'({1'b1, 4'd0, 4'd5}));
                    check("bp_quiet", int'({pe_trigger, bus.col_rd_req}), 0);
                end
                bus.res_ready = 1'b1;
            end
            if (!st_done && bus.col_rd_req && int'(bus.col_rd_row) == 1 && int'(bus.col_rd_col) == 0) begin
                st_done = 1'b1;
                bus.col_rd_valid = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    step();
                    check("stall_addr", int'({bus.col_rd_req, bus.col_rd_row, bus.col_rd_col}), int'({1'b1, 4'd1, 4'd0}));
                    check("stall_noload", int'(img_load_en), 0);
                end
                bus.col_rd_valid = 1'b1;
            end
            step();
            n++;
        end
        check("bp_reached", int'(bp_done), 1);
        check("stall_reached", int'(st_done), 1);
        step();
        final_counts(tbl[0]);

        // Abort (with a coincident start) while fetching for window (3,7).
        build_expect();
        clear_counts();
        start = 1'b1;
        step();
        start = 1'b0;
        hit = 1'b0;
        n = 0;
        while (!hit && n < 5000) begin
            step();
            n++;
            hit = bus.col_rd_req && int'(bus.col_rd_row) == 3 && int'(bus.col_rd_col) == 9;
        end
        check("abort_reached", int'(hit), 1);
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        check("abort_idle", outs_word(), 0);
        repeat (3) step();
        check("abort_quiet", outs_word(), 0);
        check("abort_no_done", dones, 0);
        run_sweep(tbl[0]);

        // Asynchronous reset pulse in the middle of an EMIT wait.
        build_expect();
        clear_counts();
        start = 1'b1;
        step();
        start = 1'b0;
        hit = 1'b0;
        n = 0;
        while (!hit && n < 5000) begin
            step();
            n++;
            hit = bus.res_valid && int'(bus.res_row) == 2 && int'(bus.res_col) == 4;
            if (hit) bus.res_ready = 1'b0;
        end
        check("emit_reached", int'(hit), 1);
        #3;
        rst_ni = 1'b0;
        #1;
        check("rst_async_outs", outs_word(), 0);
        #13;
        rst_ni = 1'b1;
        bus.res_ready = 1'b1;
        #1;
        check("rst_release_outs", outs_word(), 0);
        repeat (2) step();
        check("rst_idle", outs_word(), 0);
        run_sweep(tbl[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
